// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage-register state encoding, default
// bundle widths, and control-bundle field offsets for stages that pack/unpack.
package pipe_pkg;

  // Stage-register occupancy states; the encoding doubles as the beat count.
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_CTRL_W = 12;
  localparam int unsigned PIPE_DATA_W = 96;

  // Control-bundle field offsets (LSB positions) and widths.
  localparam int unsigned CTRL_MEM_RE_BIT    = 0;
  localparam int unsigned CTRL_MEM_WE_BIT    = 1;
  localparam int unsigned CTRL_REG_WRITE_BIT = 2;
  localparam int unsigned CTRL_ALU_OP_LSB    = 3;
  localparam int unsigned CTRL_ALU_OP_W      = 4;
  localparam int unsigned CTRL_SRC_SEL_LSB   = 7;
  localparam int unsigned CTRL_SRC_SEL_W     = 2;
  localparam int unsigned CTRL_WB_SEL_LSB    = 9;
  localparam int unsigned CTRL_WB_SEL_W      = 3;

endpackage

// File: rtl/pipe_entry.sv
// One held beat: valid + control + datapath register with load/clear.
// clear drops valid and zeroes control but keeps the datapath value.
// Ports: clk, reset (async, active-high), load, clear, d_ctrl, d_data,
//        q_valid, q_ctrl, q_data.
module pipe_entry #(
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // Clear wins over load so a flush always empties the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline stage register with valid/ready handshake and flush.
// Main entry drives out_*; skid entry catches the beat accepted while the
// head is stalled, so in_ready depends only on registers.
// Ports: clk, reset (async, active-high), flush, in_valid/in_ready/in_ctrl/
//        in_data, out_valid/out_ready/out_ctrl/out_data, occupancy.
// Optional: define PIPE_SKID_PERF_EN to add stall_cnt/bubble_cnt counters.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  pipe_state_e state_q, state_d;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              acc, pop;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  // Entry valids track the state: main valid <=> not EMPTY, skid valid <=> FULL.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign occupancy = state_q;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= PIPE_EMPTY;
    else       state_q <= state_d;
  end

  // Next state and entry load/clear strobes; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = PIPE_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (acc) begin
            main_load = 1'b1;
            state_d   = PIPE_ONE;
          end
        end
        PIPE_ONE: begin
          if (acc && pop) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            state_d   = PIPE_FULL;
          end else if (pop) begin
            main_clear = 1'b1;
            state_d    = PIPE_EMPTY;
          end
        end
        PIPE_FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = PIPE_ONE;
          end
        end
        default: begin
          state_d    = PIPE_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Main refills from the skid when draining FULL, else from the input.
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_data  (out_data)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_ctrl  (in_ctrl),
    .d_data  (in_data),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data)
  );

`ifdef PIPE_SKID_PERF_EN
  // Saturating stall/bubble counters, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= 16'd0;
      bubble_cnt <= 16'd0;
    end else if (flush) begin
      stall_cnt  <= 16'd0;
      bubble_cnt <= 16'd0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (!out_valid && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed + random bench for pipe_skid_reg with a FIFO scoreboard.
module tb_pipe_skid_reg;
  localparam int unsigned DATA_W = 96;
  localparam int unsigned CTRL_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_SKID_PERF_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;
  int unsigned       m_stall, m_bubble;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;
  int seen_55 = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Score the upcoming edge from pre-edge signals, then advance one cycle.
  task automatic step();
    logic  acc, pop;
    beat_t b;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (!out_valid) chk("ctrl_gate", 128'(out_ctrl), 128'd0);
    if (out_valid && out_data == 96'h55) seen_55++;
`ifdef PIPE_SKID_PERF_EN
    if (flush) begin
      m_stall = 0; m_bubble = 0;
    end else begin
      if (out_valid && !out_ready && m_stall != 32'hFFFF) m_stall++;
      if (!out_valid && m_bubble != 32'hFFFF) m_bubble++;
    end
`endif
    if (flush) begin
      sb.delete();
    end else begin
      if (pop) begin
        chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
        if (sb.size() != 0) begin
          b = sb.pop_front();
          chk("out_data", 128'(out_data), 128'(b.data));
          chk("out_ctrl", 128'(out_ctrl), 128'(b.ctrl));
        end
      end
      if (acc) sb.push_back({in_ctrl, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
`ifdef PIPE_SKID_PERF_EN
    m_stall = 0; m_bubble = 0;
`endif
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_occupancy", 128'(occupancy), 128'd0);
    chk("rst_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Streaming: 8 back-to-back beats with 1-cycle latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 96'(i);
      in_ctrl  = 12'(i);
      chk("stream_in_ready", 128'(in_ready), 128'd1);
      step();
      chk("stream_latency", 128'(out_data), 128'(i));
      chk("stream_valid", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 128'(occupancy), 128'd0);

    // Backpressure: A and B held, C stalls until the head drains.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'hA; in_ctrl = 12'h00A; step();
    in_data = 96'hB; in_ctrl = 12'h00B; step();
    in_data = 96'hC; in_ctrl = 12'h00C;
    chk("bp_occupancy", 128'(occupancy), 128'd2);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    chk("bp_head", 128'(out_data), 128'hA);
    step();
    chk("bp_hold_head", 128'(out_data), 128'hA);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (in_valid && in_ready) begin step(); in_valid = 1'b0; end
      else step();
    end
    chk("bp_c_accepted", 128'(in_valid), 128'd0);
    chk("bp_sb_empty", 128'(sb.size()), 128'd0);
    chk("bp_occ_empty", 128'(occupancy), 128'd0);

    // Flush priority over an incoming beat.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'h11; in_ctrl = 12'h011; step();
    chk("fl_occ_one", 128'(occupancy), 128'd1);
    seen_55 = 0;
    flush = 1'b1; in_data = 96'h55; in_ctrl = 12'hFFF; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 128'(out_valid), 128'd0);
    chk("fl_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("fl_occupancy", 128'(occupancy), 128'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("fl_no_55", 128'(seen_55), 128'd0);

    // Reset mid-stream with two beats held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'h21; in_ctrl = 12'h021; step();
    in_data = 96'h22; in_ctrl = 12'h022; step();
    in_valid = 1'b0;
    chk("mr_occ_full", 128'(occupancy), 128'd2);
    #2 reset = 1'b1;
    #1;
    chk("mr_out_valid", 128'(out_valid), 128'd0);
    chk("mr_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("mr_out_data", 128'(out_data), 128'd0);
    chk("mr_in_ready", 128'(in_ready), 128'd1);
    chk("mr_occupancy", 128'(occupancy), 128'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef PIPE_SKID_PERF_EN
    m_stall = 0; m_bubble = 0;
`endif

    // Random valid/ready/flush traffic.
    for (int k = 0; k < 10000; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 63) == 0);
      in_data   = {32'($urandom), 32'($urandom), 32'($urandom)};
      in_ctrl   = 12'($urandom);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("rand_sb_empty", 128'(sb.size()), 128'd0);

`ifdef PIPE_SKID_PERF_EN
    // Saturate the stall counter, then flush both counters.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'h77; in_ctrl = 12'h077; step();
    in_valid = 1'b0;
    for (int k = 0; k < 70000; k++) step();
    chk("perf_stall_sat", 128'(stall_cnt), 128'(m_stall));
    chk("perf_stall_ffff", 128'(stall_cnt), 128'hFFFF);
    chk("perf_bubble", 128'(bubble_cnt), 128'(m_bubble));
    flush = 1'b1; step();
    flush = 1'b0;
    chk("perf_stall_clr", 128'(stall_cnt), 128'd0);
    chk("perf_bubble_clr", 128'(bubble_cnt), 128'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
